// File: rtl/qu_instr_decoder.sv
// qu_instr_decoder
//
// Decode stage of the Qu core. Turns RV32I instruction words into register
// fields, a sign-extended immediate, an operation class and an illegal flag.
// Decoding is purely combinational into a two-entry elastic buffer: an output
// register plus a skid register. That keeps throughput at one instruction per
// clock while in_ready_o comes straight from a flop.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid and payload stable
// until that edge. The decoder keeps its output fields stable while
// out_valid_o && !out_ready_i.
//
// Ports
//   clk, rst                   core clock, asynchronous active-high reset
//   in_valid_i / in_ready_o    fetch-side handshake
//   instr_i, pc_i              raw instruction word and its PC
//   flush_i                    drops every buffered entry and the input
//                              offered in the same cycle
//   out_valid_o / out_ready_i  issue-side handshake
//   pc_o, op_class_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, imm_o,
//   rd_we_o, illegal_o         decoded entry
module qu_instr_decoder #(
  parameter int PC_WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         instr_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [3:0]          op_class_o,
  output logic [4:0]          rd_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic [2:0]          funct3_o,
  output logic [6:0]          funct7_o,
  output logic [31:0]         imm_o,
  output logic                rd_we_o,
  output logic                illegal_o
);

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;

  // Operation classes
  localparam logic [3:0] CLS_R       = 4'd0;
  localparam logic [3:0] CLS_I       = 4'd1;
  localparam logic [3:0] CLS_LOAD    = 4'd2;
  localparam logic [3:0] CLS_S       = 4'd3;
  localparam logic [3:0] CLS_B       = 4'd4;
  localparam logic [3:0] CLS_JAL     = 4'd5;
  localparam logic [3:0] CLS_JALR    = 4'd6;
  localparam logic [3:0] CLS_LUI     = 4'd7;
  localparam logic [3:0] CLS_AUIPC   = 4'd8;
  localparam logic [3:0] CLS_SYS     = 4'd9;
  localparam logic [3:0] CLS_CSR     = 4'd10;
  localparam logic [3:0] CLS_FENCE   = 4'd11;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [3:0]          op_class;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [31:0]         imm;
    logic                rd_we;
    logic                illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the input word
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  dec_class;
  logic [31:0] dec_imm;
  logic        dec_ok;
  logic        dec_no_rd;
  entry_t      dec;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  always_comb begin
    dec_class = CLS_ILLEGAL;
    dec_imm   = 32'd0;
    dec_ok    = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_class = CLS_R;
        // funct7 0x20 only exists for SUB and SRA
        dec_ok = (funct7 == 7'h00) ||
                 ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec_class = CLS_I;
        dec_imm   = imm_i;
        // only the shifts constrain imm[11:5]
        if (funct3 == 3'b001)      dec_ok = (funct7 == 7'h00);
        else if (funct3 == 3'b101) dec_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       dec_ok = 1'b1;
      end
      OPC_LOAD: begin
        dec_class = CLS_LOAD;
        dec_imm   = imm_i;
        dec_ok    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        dec_class = CLS_S;
        dec_imm   = imm_s;
        dec_ok    = (funct3 <= 3'b010);
      end
      OPC_BRANCH: begin
        dec_class = CLS_B;
        dec_imm   = imm_b;
        dec_ok    = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_JAL: begin
        dec_class = CLS_JAL;
        dec_imm   = imm_j;
        dec_ok    = 1'b1;
      end
      OPC_JALR: begin
        dec_class = CLS_JALR;
        dec_imm   = imm_i;
        dec_ok    = (funct3 == 3'b000);
      end
      OPC_LUI: begin
        dec_class = CLS_LUI;
        dec_imm   = imm_u;
        dec_ok    = 1'b1;
      end
      OPC_AUIPC: begin
        dec_class = CLS_AUIPC;
        dec_imm   = imm_u;
        dec_ok    = 1'b1;
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          // ECALL (imm 0) / EBREAK (imm 1) with rs1 = rd = x0 only
          dec_class = CLS_SYS;
          dec_ok    = (instr_i[31:21] == 11'd0) && (instr_i[19:15] == 5'd0) &&
                      (instr_i[11:7] == 5'd0);
        end else begin
          dec_class = CLS_CSR;
          dec_imm   = imm_i;
          dec_ok    = (funct3 != 3'b100);
        end
      end
      OPC_FENCE: begin
        dec_class = CLS_FENCE;
        dec_ok    = (funct3 <= 3'b001);
      end
      default: begin
        dec_class = CLS_ILLEGAL;
        dec_ok    = 1'b0;
      end
    endcase
  end

  assign dec_no_rd = (dec_class == CLS_S) || (dec_class == CLS_B) ||
                     (dec_class == CLS_SYS) || (dec_class == CLS_FENCE);

  always_comb begin
    dec.pc       = pc_i;
    dec.rd       = instr_i[11:7];
    dec.rs1      = instr_i[19:15];
    dec.rs2      = instr_i[24:20];
    dec.funct3   = funct3;
    dec.funct7   = funct7;
    // illegal entries keep their raw fields but lose class, imm and rd write
    dec.op_class = dec_ok ? dec_class : CLS_ILLEGAL;
    dec.imm      = dec_ok ? dec_imm : 32'd0;
    dec.rd_we    = dec_ok && !dec_no_rd && (instr_i[11:7] != 5'd0);
    dec.illegal  = !dec_ok;
  end

  // ---------------------------------------------------------------------------
  // Output register + skid register
  // ---------------------------------------------------------------------------
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   accept;
  logic   out_free;

  assign in_ready_o = !skid_valid_q;
  assign accept     = in_valid_i && in_ready_o;
  // output register can take a new entry this cycle
  assign out_free   = !out_valid_q || out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // skid holds the older entry; input is blocked while it is full
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign pc_o        = out_q.pc;
  assign op_class_o  = out_q.op_class;
  assign rd_o        = out_q.rd;
  assign rs1_o       = out_q.rs1;
  assign rs2_o       = out_q.rs2;
  assign funct3_o    = out_q.funct3;
  assign funct7_o    = out_q.funct7;
  assign imm_o       = out_q.imm;
  assign rd_we_o     = out_q.rd_we;
  assign illegal_o   = out_q.illegal;

endmodule
